// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller driving a cascaded 74161 counter chain.
// Sequences reset-vector load, branch loads and post-fetch increments.
module pc_fetch_ctrl #(
  parameter int unsigned     WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Counter_Q,
  input  logic             Counter_RCO,
  input  logic             Fetch_req,
  input  logic             Branch_req,
  input  logic [WIDTH-1:0] Branch_target,
  input  logic             Halt,
  input  logic             Mem_ready,
  output logic             Load_bar,
  output logic             ENT,
  output logic             ENP,
  output logic [WIDTH-1:0] D,
  output logic             Mem_req,
  output logic [WIDTH-1:0] Mem_addr,
  output logic             Fetch_valid,
  output logic             Branch_ack,
  output logic             Wrap
);

  typedef enum logic [2:0] {
    StVec    = 3'd0,
    StIdle   = 3'd1,
    StFetch  = 3'd2,
    StAdv    = 3'd3,
    StBranch = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             wrap_q, wrap_d;

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q <= StVec;
      d_q     <= RESET_VECTOR;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      wrap_q  <= wrap_d;
    end
  end

  // Control outputs depend on state_q only; inputs affect next state alone.
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    wrap_d      = wrap_q;
    Load_bar    = 1'b1;
    ENT         = 1'b0;
    ENP         = 1'b0;
    Mem_req     = 1'b0;
    Fetch_valid = 1'b0;
    Branch_ack  = 1'b0;
    case (state_q)
      StVec: begin
        Load_bar = 1'b0;
        state_d  = StIdle;
      end
      StIdle: begin
        if (!Halt) begin
          if (Branch_req) begin
            d_d     = Branch_target;
            state_d = StBranch;
          end else if (Fetch_req) begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        Mem_req = 1'b1;
        if (Mem_ready) state_d = StAdv;
      end
      StAdv: begin
        Fetch_valid = 1'b1;
        ENT         = 1'b1;
        ENP         = 1'b1;
        if (Counter_RCO) wrap_d = 1'b1;
        state_d = StIdle;
      end
      StBranch: begin
        Load_bar   = 1'b0;
        Branch_ack = 1'b1;
        wrap_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StVec;
    endcase
  end

  assign D        = d_q;
  assign Wrap     = wrap_q;
  assign Mem_addr = Counter_Q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl with a behavioural 74161 chain model.
module tb_pc_fetch_ctrl;

  localparam int unsigned W = 16;

  logic         Clk = 1'b0;
  logic         Clear = 1'b1;
  logic [W-1:0] Counter_Q;
  logic         Counter_RCO;
  logic         Fetch_req = 1'b0;
  logic         Branch_req = 1'b0;
  logic [W-1:0] Branch_target = '0;
  logic         Halt = 1'b0;
  logic         Mem_ready = 1'b0;
  logic         Load_bar, ENT, ENP, Mem_req, Fetch_valid, Branch_ack, Wrap;
  logic [W-1:0] D, Mem_addr;

  pc_fetch_ctrl #(.WIDTH(W), .RESET_VECTOR(16'h0100)) dut (
    .Clk(Clk), .Clear(Clear), .Counter_Q(Counter_Q), .Counter_RCO(Counter_RCO),
    .Fetch_req(Fetch_req), .Branch_req(Branch_req), .Branch_target(Branch_target),
    .Halt(Halt), .Mem_ready(Mem_ready), .Load_bar(Load_bar), .ENT(ENT), .ENP(ENP),
    .D(D), .Mem_req(Mem_req), .Mem_addr(Mem_addr), .Fetch_valid(Fetch_valid),
    .Branch_ack(Branch_ack), .Wrap(Wrap)
  );

  always #5 Clk = ~Clk;

  // 74161 chain: clear shares the system Clear, load beats count, RCO ripples up.
  logic [W-1:0] chain_q;
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear)                chain_q <= '0;
    else if (!Load_bar)       chain_q <= D;
    else if (ENT && ENP)      chain_q <= chain_q + 1'b1;
  end
  assign Counter_Q   = chain_q;
  assign Counter_RCO = ENT && (chain_q == 16'hFFFF);

  typedef struct {
    bit           is_branch;
    logic [W-1:0] addr;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input bit is_branch, input logic [W-1:0] addr);
    exp_t e;
    e.is_branch = is_branch;
    e.addr      = addr;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per Fetch_valid/Branch_ack pulse.
  always @(negedge Clk) begin
    exp_t e;
    if (!Clear) begin
      if ((ENT || ENP) && !Load_bar) begin
        n_total++;
        $display("FAIL enable_with_load: ENT=%b ENP=%b Load_bar=%b", ENT, ENP, Load_bar);
      end
      if (Fetch_valid || Branch_ack) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pulse: Fetch_valid=%b Branch_ack=%b, expected none",
                   Fetch_valid, Branch_ack);
        end else begin
          e = exp_q.pop_front();
          check("pulse_is_branch", {31'd0, Branch_ack}, {31'd0, e.is_branch});
          check("pulse_is_fetch", {31'd0, Fetch_valid}, {31'd0, !e.is_branch});
          if (e.is_branch) check("branch_D", {16'd0, D}, {16'd0, e.addr});
          else             check("fetch_addr", {16'd0, Mem_addr}, {16'd0, e.addr});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // 1: reset and vector load
    tick(); tick();
    check("rst_load_bar", {31'd0, Load_bar}, 32'd0);
    check("rst_D", {16'd0, D}, 32'h0100);
    check("rst_ent_enp", {30'd0, ENT, ENP}, 32'd0);
    check("rst_pulses", {29'd0, Mem_req, Fetch_valid, Branch_ack}, 32'd0);
    check("rst_wrap", {31'd0, Wrap}, 32'd0);
    Clear = 1'b0;
    tick();
    check("vec_Q", {16'd0, Counter_Q}, 32'h0100);
    check("vec_load_bar_done", {31'd0, Load_bar}, 32'd1);
    check("idle_pulses", {29'd0, Mem_req, Fetch_valid, Branch_ack}, 32'd0);

    // 2: fetch with memory ready
    Mem_ready = 1'b1;
    Fetch_req = 1'b1;
    push(1'b0, 16'h0100);
    tick();
    Fetch_req = 1'b0;
    check("f2_mem_req", {31'd0, Mem_req}, 32'd1);
    check("f2_mem_addr", {16'd0, Mem_addr}, 32'h0100);
    tick();
    check("f2_adv_ent", {30'd0, ENT, ENP}, 32'd3);
    check("f2_adv_mem_req", {31'd0, Mem_req}, 32'd0);
    tick();
    check("f2_Q", {16'd0, Counter_Q}, 32'h0101);

    // 3: memory stall
    Mem_ready = 1'b0;
    Fetch_req = 1'b1;
    tick();
    Fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("f3_stall_mem_req", {31'd0, Mem_req}, 32'd1);
      check("f3_stall_ent_enp", {30'd0, ENT, ENP}, 32'd0);
      check("f3_stall_Q", {16'd0, Counter_Q}, 32'h0101);
      tick();
    end
    Mem_ready = 1'b1;
    push(1'b0, 16'h0101);
    tick();
    tick();
    check("f3_Q", {16'd0, Counter_Q}, 32'h0102);

    // 4: branch beats fetch
    Branch_target = 16'h1234;
    Branch_req = 1'b1;
    Fetch_req = 1'b1;
    push(1'b1, 16'h1234);
    tick();
    Branch_req = 1'b0;
    check("b4_mem_req", {31'd0, Mem_req}, 32'd0);
    check("b4_load_bar", {31'd0, Load_bar}, 32'd0);
    tick();
    check("b4_Q", {16'd0, Counter_Q}, 32'h1234);
    check("b4_idle_mem_req", {31'd0, Mem_req}, 32'd0);
    push(1'b0, 16'h1234);
    tick();
    Fetch_req = 1'b0;
    check("b4_fetch_addr", {16'd0, Mem_addr}, 32'h1234);
    tick();
    tick();
    check("b4_Q_inc", {16'd0, Counter_Q}, 32'h1235);

    // 5: wrap-around and clearing by branch
    Branch_target = 16'hFFFF;
    Branch_req = 1'b1;
    push(1'b1, 16'hFFFF);
    tick();
    Branch_req = 1'b0;
    tick();
    check("w5_Q_ffff", {16'd0, Counter_Q}, 32'hFFFF);
    Fetch_req = 1'b1;
    push(1'b0, 16'hFFFF);
    tick();
    Fetch_req = 1'b0;
    tick();
    check("w5_rco", {31'd0, Counter_RCO}, 32'd1);
    tick();
    check("w5_Q_zero", {16'd0, Counter_Q}, 32'h0000);
    check("w5_wrap_set", {31'd0, Wrap}, 32'd1);
    tick();
    check("w5_wrap_sticky", {31'd0, Wrap}, 32'd1);
    Branch_target = 16'h0010;
    Branch_req = 1'b1;
    push(1'b1, 16'h0010);
    tick();
    Branch_req = 1'b0;
    tick();
    check("w5_wrap_clr", {31'd0, Wrap}, 32'd0);
    check("w5_Q_0010", {16'd0, Counter_Q}, 32'h0010);

    // 6: Clear during a stalled fetch, then Halt
    Mem_ready = 1'b0;
    Fetch_req = 1'b1;
    tick();
    Fetch_req = 1'b0;
    check("c6_mem_req", {31'd0, Mem_req}, 32'd1);
    Clear = 1'b1;
    Mem_ready = 1'b1;
    Branch_req = 1'b1;
    #1;
    check("c6_mem_req_drop", {31'd0, Mem_req}, 32'd0);
    check("c6_load_bar", {31'd0, Load_bar}, 32'd0);
    check("c6_pulses", {30'd0, Fetch_valid, Branch_ack}, 32'd0);
    check("c6_D", {16'd0, D}, 32'h0100);
    tick();
    tick();
    Branch_req = 1'b0;
    Clear = 1'b0;
    tick();
    check("c6_Q_vec", {16'd0, Counter_Q}, 32'h0100);
    Halt = 1'b1;
    Fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c6_halt_mem_req", {31'd0, Mem_req}, 32'd0);
    end
    Fetch_req = 1'b0;
    Halt = 1'b0;
    tick();
    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
